element_majority_bundle: RTL and testbench
==========================================

Name: element_majority_bundle

Overview:
- Bundling kernel: element-wise majority vote across a stream of N hypervector words (N ≤ MAX_INPUTS).
- Sits downstream of the bind/bundle memory mapper. It uses the same kernel handshake as the multiplication kernel, so the mapper can drive either one.
- The mapper streams words framed by first/last. The block returns one bundled word plus done, and the mapper writes that word back to DPRAM.

Parameters:
- HV_DATA_WIDTH, 32, width of one hypervector word.
- MAX_INPUTS, 31, maximum beats per bundle.
- COUNT_WIDTH, $clog2(MAX_INPUTS+1), per-bit counter width.
- TIE_VALUE, 1'b0, output bit when ones count × 2 == N.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, active-low, asynchronous.
- valid  in  1  data_in beat present.
- first  in  1  beat is the first of a bundle.
- last  in  1  beat is the last of a bundle.
- data_in  in  HV_DATA_WIDTH  input word.
- data_out  out  HV_DATA_WIDTH  bundled result.
- ready  out  1  block accepts beats.
- done  out  1  one-cycle result strobe.
- overflow  out  1  sticky: beats were dropped in the current bundle.

Behaviour:
- Interface: one clock (clk). reset_n is asynchronous and active-low. All state is cleared on reset assertion, independent of clk.
- Reset values: data_out=0, done=0, overflow=0, ready=1, state=IDLE, all counters=0, n=0.
- Beat acceptance: a beat is accepted on a rising edge with valid=1 and ready=1. ready=1 only in IDLE and ACCUM.
- FSM states: IDLE, ACCUM, RESOLVE, DONE.
- IDLE:
  - Accepted beat with first=1: counters load the data_in bits (0/1), n=1, overflow cleared.
  - If last=1 on that beat, go to RESOLVE; otherwise go to ACCUM.
  - Accepted beat with first=0 is ignored and the state stays IDLE.
- ACCUM:
  - Accepted beat with first=1 restarts the bundle, exactly as the IDLE load; the partial bundle is discarded.
  - Otherwise, if n < MAX_INPUTS: each counter[i] += data_in[i] and n += 1.
  - If n == MAX_INPUTS: the beat is dropped, counters and n are unchanged, and overflow is set to 1.
  - last=1 on an accepted beat goes to RESOLVE after that beat is applied or dropped.
- RESOLVE: lasts one cycle. data_out[i] is registered as 1 if 2·counter[i] > n, 0 if 2·counter[i] < n, and TIE_VALUE if equal. Next state is DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: done is high in the cycle following the second rising edge after the edge that accepted the last beat.
- data_out is valid while done=1 and is held until the next RESOLVE. A new first beat does not alter data_out.
- overflow holds its value until the next first beat or reset.
- Arithmetic:
  - The comparison is 2·counter vs n at COUNT_WIDTH+1 bits. No counter can wrap, because saturation is enforced by n.
- Simultaneous events:
  - first=1 and last=1 on one beat: single-input bundle; the result equals data_in.
  - valid=0 with first or last high: no effect.
  - valid asserted during RESOLVE or DONE: not accepted (ready=0). The mapper must hold the beat.
- Reset mid-operation: an immediate return to reset values. No done is emitted for the aborted bundle.

Decomposition:
- Shared package hdc_kernel_pkg holds:
  - the kernel FSM state enum (IDLE/ACCUM/RESOLVE/DONE), shared by all kernels;
  - a count-width function;
  - the default HV_DATA_WIDTH.
- One sub-module, majority_bit_counter. It is a single-bit COUNT_WIDTH counter with load, increment enable and a tie-resolved compare output. It is instantiated HV_DATA_WIDTH times in a generate loop.
- The FSM, n counter and overflow logic stay in the top module.

Test Plan:
- Three-input majority: beats 0xFFFF0000 (first), 0xFF00FF00, 0xF0F0F0F0 (last). Required: data_out=0xFFF0F000, done high for one cycle, two edges after the last beat.
- Single-input bundle: one beat 0xDEADBEEF with first=last=1. Required: data_out=0xDEADBEEF, done=1, overflow=0.
- Tie handling with TIE_VALUE=0: beats 0xFFFF0000, 0x00FF00FF. Required: data_out=0x00FF0000. Repeat with TIE_VALUE=1; required: data_out=0xFFFF00FF.
- Saturation with MAX_INPUTS=31: 31 beats of 0xFFFFFFFF, then a 32nd beat of 0x00000000 with last=1. Required: the 32nd beat is dropped, overflow=1, data_out=0xFFFFFFFF.
- Restart: first 0x0000FFFF, then 0x0000FFFF, then first+last 0xA5A5A5A5. Required: data_out=0xA5A5A5A5, and only one done pulse.
- Reset mid-ACCUM: two beats accepted, then reset_n pulsed low between clock edges. Required: done never asserts, data_out=0, ready=1 immediately; a subsequent bundle works normally.

Source files
------------

// File: rtl/hdc_kernel_pkg.sv
// hdc_kernel_pkg: shared kernel FSM states, count-width helper and default word width
package hdc_kernel_pkg;
  localparam int HV_DATA_WIDTH_DEFAULT = 32;
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} kernel_state_t;
  function automatic int count_width(input int max_inputs);
    return $clog2(max_inputs + 1);
  endfunction
endpackage

// File: rtl/majority_bit_counter.sv
// majority_bit_counter: per-bit ones counter with tie-resolved majority against beat count n
module majority_bit_counter #(
  parameter int   COUNT_WIDTH = 5,
  parameter logic TIE_VALUE   = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic                   inc,
  input  logic                   bit_in,
  input  logic [COUNT_WIDTH-1:0] n,
  output logic                   maj
);
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH:0]   twice;
  logic [COUNT_WIDTH:0]   total;
  assign twice = {cnt, 1'b0};
  assign total = {1'b0, n};
  assign maj = twice > total ? 1'b1 : twice < total ? 1'b0 : TIE_VALUE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= COUNT_WIDTH'(bit_in);
    else if (inc) cnt <= cnt + COUNT_WIDTH'(bit_in);
endmodule

// File: rtl/element_majority_bundle.sv
// element_majority_bundle: element-wise majority vote over a first/last framed word stream
module element_majority_bundle
  import hdc_kernel_pkg::*;
#(
  parameter int   HV_DATA_WIDTH = HV_DATA_WIDTH_DEFAULT,
  parameter int   MAX_INPUTS    = 31,
  parameter int   COUNT_WIDTH   = count_width(MAX_INPUTS),
  parameter logic TIE_VALUE     = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid,
  input  logic                     first,
  input  logic                     last,
  input  logic [HV_DATA_WIDTH-1:0] data_in,
  output logic [HV_DATA_WIDTH-1:0] data_out,
  output logic                     ready,
  output logic                     done,
  output logic                     overflow
);
  kernel_state_t state;
  logic [COUNT_WIDTH-1:0] n;
  logic [HV_DATA_WIDTH-1:0] maj;
  logic accept, start, inc;
  assign ready = state == IDLE || state == ACCUM;
  assign accept = valid && ready;
  assign start = accept && first;
  // n saturates at MAX_INPUTS, which also bounds every per-bit counter
  assign inc = accept && !first && state == ACCUM && n < COUNT_WIDTH'(MAX_INPUTS);
  for (genvar g = 0; g < HV_DATA_WIDTH; g++) begin : g_bit
    majority_bit_counter #(.COUNT_WIDTH(COUNT_WIDTH), .TIE_VALUE(TIE_VALUE)) u_cnt (
      .clk(clk), .reset_n(reset_n), .load(start), .inc(inc),
      .bit_in(data_in[g]), .n(n), .maj(maj[g])
    );
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      n <= '0;
      data_out <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, ACCUM: if (accept) begin
          if (first) begin
            n <= COUNT_WIDTH'(1);
            overflow <= 1'b0;
          end else if (inc) n <= n + 1'b1;
          else if (state == ACCUM) overflow <= 1'b1;
          if (first || state == ACCUM) state <= last ? RESOLVE : ACCUM;
        end
        RESOLVE: begin
          data_out <= maj;
          state <= DONE;
        end
        default: begin
          done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_element_majority_bundle.sv
// tb_element_majority_bundle: directed and random bundles checked against a queue-based majority model
module tb_element_majority_bundle;
  logic clk = 1'b0, reset_n = 1'b0, valid = 1'b0, first = 1'b0, last = 1'b0;
  logic [31:0] data_in = '0, data_out, data_out1;
  logic ready, done, overflow, ready1, done1, overflow1;
  int checks = 0, errors = 0, pulses = 0;
  logic [31:0] q[$];
  bit ovf_m = 1'b0, active = 1'b0;

  always #5 clk = ~clk;

  element_majority_bundle dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .first(first), .last(last),
    .data_in(data_in), .data_out(data_out), .ready(ready), .done(done), .overflow(overflow)
  );
  element_majority_bundle #(.TIE_VALUE(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .valid(valid), .first(first), .last(last),
    .data_in(data_in), .data_out(data_out1), .ready(ready1), .done(done1), .overflow(overflow1)
  );

  always @(negedge clk) if (done) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // majority of the counted words, ties resolved to tie
  function automatic logic [31:0] model(input bit tie);
    logic [31:0] r;
    int n = q.size();
    for (int b = 0; b < 32; b++) begin
      int c = 0;
      foreach (q[k]) c += int'(q[k][b]);
      r[b] = 2 * c > n ? 1'b1 : 2 * c < n ? 1'b0 : tie;
    end
    return r;
  endfunction

  task automatic send(input bit f, input bit l, input logic [31:0] d);
    @(negedge clk);
    chk("ready_beat", {31'b0, ready}, 32'd1);
    valid = 1'b1; first = f; last = l; data_in = d;
    if (f) begin
      q.delete();
      ovf_m = 1'b0;
      active = 1'b1;
      q.push_back(d);
    end else if (active) begin
      if (q.size() < 31) q.push_back(d);
      else ovf_m = 1'b1;
    end
    if (l && active) active = 1'b0;
    @(posedge clk);
  endtask

  task automatic gap(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      valid = 1'b0; first = 1'(($urandom)); last = 1'(($urandom)); data_in = $urandom;
    end
  endtask

  // last beat was accepted on the preceding edge; beat offered during RESOLVE/DONE must be refused
  task automatic finish_bundle(input string tag);
    @(negedge clk);
    chk({tag, "_ready_resolve"}, {31'b0, ready}, 32'd0);
    chk({tag, "_done_e0"}, {31'b0, done}, 32'd0);
    valid = 1'b1; first = 1'b1; last = 1'b1; data_in = $urandom;
    @(negedge clk);
    chk({tag, "_ready_done"}, {31'b0, ready}, 32'd0);
    chk({tag, "_done_e1"}, {31'b0, done}, 32'd0);
    @(negedge clk);
    valid = 1'b0;
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_done1"}, {31'b0, done1}, 32'd1);
    chk({tag, "_data"}, data_out, model(1'b0));
    chk({tag, "_data_tie1"}, data_out1, model(1'b1));
    chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, ovf_m});
    @(negedge clk);
    chk({tag, "_done_off"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int p0;
    #1;
    chk("rst_data", data_out, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    gap(2);

    send(1, 0, 32'hFFFF0000); send(0, 0, 32'hFF00FF00); send(0, 1, 32'hF0F0F0F0);
    finish_bundle("three");
    chk("three_const", data_out, 32'hFFF0F000);

    send(1, 1, 32'hDEADBEEF);
    finish_bundle("single");
    chk("single_const", data_out, 32'hDEADBEEF);

    send(1, 0, 32'hFFFF0000); send(0, 1, 32'h00FF00FF);
    finish_bundle("tie");
    chk("tie0_const", data_out, 32'h00FF0000);
    chk("tie1_const", data_out1, 32'hFFFF00FF);

    send(1, 0, 32'hFFFFFFFF);
    for (int i = 0; i < 30; i++) send(0, 0, 32'hFFFFFFFF);
    send(0, 1, 32'h00000000);
    finish_bundle("sat");
    chk("sat_const", data_out, 32'hFFFFFFFF);
    chk("sat_ovf_const", {31'b0, overflow}, 32'd1);
    gap(2);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);

    p0 = pulses;
    send(1, 0, 32'h0000FFFF);
    @(negedge clk);
    chk("ovf_cleared", {31'b0, overflow}, 32'd0);
    chk("data_held", data_out, 32'hFFFFFFFF);
    send(0, 0, 32'h0000FFFF); send(1, 1, 32'hA5A5A5A5);
    finish_bundle("restart");
    chk("restart_const", data_out, 32'hA5A5A5A5);
    @(negedge clk);
    chk("restart_pulses", pulses - p0, 32'd1);

    p0 = pulses;
    send(1, 0, 32'h12345678); send(0, 0, 32'h0F0F0F0F);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, ready}, 32'd1);
    chk("mid_rst_data", data_out, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    #1 reset_n = 1'b1;
    q.delete(); active = 1'b0; ovf_m = 1'b0;
    gap(6);
    chk("mid_rst_no_done", pulses - p0, 32'd0);
    send(1, 0, 32'hAAAA5555); send(0, 0, 32'hAAAA0000); send(0, 1, 32'h0000FFFF);
    finish_bundle("post_rst");

    for (int t = 0; t < 25; t++) begin
      int len = $urandom_range(1, 35);
      send(1, len == 1, $urandom);
      for (int i = 1; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
        send($urandom_range(0, 9) == 0, i == len - 1,
             $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom);
      end
      finish_bundle("rand");
      gap($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
